// File: rtl/csa_operand_packer.sv
// ==== csa_operand_packer : groups a 4-bit operand stream into zero-padded CSA triples ====
// ==== rev 1.0                                                                         ====
`default_nettype none

module csa_operand_packer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [3:0] c,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_cnt,
  output logic       out_last,
  output logic [7:0] grp_cnt
);

  typedef enum logic [1:0] {
    S0   = 2'd0,
    S1   = 2'd1,
    S2   = 2'd2,
    PEND = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] col_a_q, col_a_d, col_b_q, col_b_d, col_c_q, col_c_d;
  logic [1:0] col_cnt_q, col_cnt_d;
  logic       col_last_q, col_last_d;
  logic [3:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [1:0] out_cnt_q, out_cnt_d;
  logic       out_last_q, out_last_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] grp_cnt_q, grp_cnt_d;

  logic       out_free, accept, complete, consume;
  logic [3:0] tri_a, tri_b, tri_c;
  logic [1:0] tri_cnt;

  always_comb begin
    out_free = !out_valid_q || out_ready;
    consume  = out_valid_q && out_ready;
    accept   = in_valid && (state_q != PEND);
    complete = accept && (in_last || (state_q == S2));

    // Triple as it would look if the current operand closed it
    tri_a   = col_a_q;
    tri_b   = 4'd0;
    tri_c   = 4'd0;
    tri_cnt = 2'd3;
    case (state_q)
      S0: begin
        tri_a   = in_data;
        tri_cnt = 2'd1;
      end
      S1: begin
        tri_b   = in_data;
        tri_cnt = 2'd2;
      end
      S2: begin
        tri_b   = col_b_q;
        tri_c   = in_data;
        tri_cnt = 2'd3;
      end
      PEND: ;
    endcase

    state_d     = state_q;
    col_a_d     = col_a_q;
    col_b_d     = col_b_q;
    col_c_d     = col_c_q;
    col_cnt_d   = col_cnt_q;
    col_last_d  = col_last_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    out_cnt_d   = out_cnt_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q && !out_ready;
    grp_cnt_d   = grp_cnt_q + {7'd0, consume};

    if (state_q == PEND) begin
      if (out_free) begin
        a_d         = col_a_q;
        b_d         = col_b_q;
        c_d         = col_c_q;
        out_cnt_d   = col_cnt_q;
        out_last_d  = col_last_q;
        out_valid_d = 1'b1;
        state_d     = S0;
        col_a_d     = 4'd0;
        col_b_d     = 4'd0;
        col_c_d     = 4'd0;
        col_cnt_d   = 2'd0;
        col_last_d  = 1'b0;
      end
    end else if (complete) begin
      if (out_free) begin
        a_d         = tri_a;
        b_d         = tri_b;
        c_d         = tri_c;
        out_cnt_d   = tri_cnt;
        out_last_d  = in_last;
        out_valid_d = 1'b1;
        state_d     = S0;
        col_a_d     = 4'd0;
        col_b_d     = 4'd0;
        col_c_d     = 4'd0;
        col_cnt_d   = 2'd0;
        col_last_d  = 1'b0;
      end else begin
        // Park the finished triple until the output register drains
        col_a_d    = tri_a;
        col_b_d    = tri_b;
        col_c_d    = tri_c;
        col_cnt_d  = tri_cnt;
        col_last_d = in_last;
        state_d    = PEND;
      end
    end else if (accept) begin
      if (state_q == S0) begin
        col_a_d = in_data;
        state_d = S1;
      end else begin
        col_b_d = in_data;
        state_d = S2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S0;
      col_a_q     <= 4'd0;
      col_b_q     <= 4'd0;
      col_c_q     <= 4'd0;
      col_cnt_q   <= 2'd0;
      col_last_q  <= 1'b0;
      a_q         <= 4'd0;
      b_q         <= 4'd0;
      c_q         <= 4'd0;
      out_cnt_q   <= 2'd0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      grp_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      col_a_q     <= col_a_d;
      col_b_q     <= col_b_d;
      col_c_q     <= col_c_d;
      col_cnt_q   <= col_cnt_d;
      col_last_q  <= col_last_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      out_cnt_q   <= out_cnt_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      grp_cnt_q   <= grp_cnt_d;
    end
  end

  assign in_ready  = (state_q != PEND);
  assign a         = a_q;
  assign b         = b_q;
  assign c         = c_q;
  assign out_cnt   = out_cnt_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign grp_cnt   = grp_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_csa_operand_packer.sv
// ==== tb_csa_operand_packer : directed vector bench for csa_operand_packer ====
// ==== rev 1.0                                                              ====
`default_nettype none

module tb_csa_operand_packer;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [3:0] a, b, c;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_cnt;
  logic       out_last;
  logic [7:0] grp_cnt;

  int n_pass  = 0;
  int n_total = 0;

  csa_operand_packer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c        (c),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_cnt  (out_cnt),
    .out_last (out_last),
    .grp_cnt  (grp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] din;
    logic       vld;
    logic       lst;
    logic       ordy;
    logic       e_rdy;
    logic       e_ov;
    logic [3:0] e_a;
    logic [3:0] e_b;
    logic [3:0] e_c;
    logic [1:0] e_cnt;
    logic       e_last;
    logic [7:0] e_grp;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic drive(input logic [3:0] d, input logic v, input logic l, input logic r);
    in_data   = d;
    in_valid  = v;
    in_last   = l;
    out_ready = r;
  endtask

  task automatic check_triple(input string nm, input int ea, input int eb, input int ec,
                              input int ecnt, input int elast);
    check({nm, "_valid"}, int'(out_valid), 1);
    check({nm, "_a"},     int'(a), ea);
    check({nm, "_b"},     int'(b), eb);
    check({nm, "_c"},     int'(c), ec);
    check({nm, "_cnt"},   int'(out_cnt), ecnt);
    check({nm, "_last"},  int'(out_last), elast);
  endtask

  initial begin
    logic stall_seen;

    //          din  v  l  r  rdy ov  a     b     c     cnt   last grp
    vecs[0]  = '{4'd3,  1, 0, 1, 1, 0, 4'd0, 4'd0, 4'd0, 2'd0, 0, 8'd0};
    vecs[1]  = '{4'd5,  1, 0, 1, 1, 0, 4'd0, 4'd0, 4'd0, 2'd0, 0, 8'd0};
    vecs[2]  = '{4'd9,  1, 0, 1, 1, 1, 4'd3, 4'd5, 4'd9, 2'd3, 0, 8'd0};
    vecs[3]  = '{4'd0,  0, 0, 1, 1, 0, 4'd0, 4'd0, 4'd0, 2'd0, 0, 8'd1};
    vecs[4]  = '{4'd7,  1, 1, 1, 1, 1, 4'd7, 4'd0, 4'd0, 2'd1, 1, 8'd1};
    vecs[5]  = '{4'd2,  1, 0, 1, 1, 0, 4'd0, 4'd0, 4'd0, 2'd0, 0, 8'd2};
    vecs[6]  = '{4'd4,  1, 1, 1, 1, 1, 4'd2, 4'd4, 4'd0, 2'd2, 1, 8'd2};
    vecs[7]  = '{4'd0,  0, 0, 1, 1, 0, 4'd0, 4'd0, 4'd0, 2'd0, 0, 8'd3};
    vecs[8]  = '{4'd6,  1, 0, 1, 1, 0, 4'd0, 4'd0, 4'd0, 2'd0, 0, 8'd3};
    vecs[9]  = '{4'd8,  1, 0, 1, 1, 0, 4'd0, 4'd0, 4'd0, 2'd0, 0, 8'd3};
    vecs[10] = '{4'd10, 1, 1, 1, 1, 1, 4'd6, 4'd8, 4'd10, 2'd3, 1, 8'd3};
    vecs[11] = '{4'd0,  0, 0, 1, 1, 0, 4'd0, 4'd0, 4'd0, 2'd0, 0, 8'd4};

    // Reset state
    rst_n = 1'b0;
    drive(4'd0, 0, 0, 0);
    tick();
    tick();
    check("rst_valid", int'(out_valid), 0);
    check("rst_abc",   int'({a, b, c}), 0);
    check("rst_cnt",   int'(out_cnt), 0);
    check("rst_last",  int'(out_last), 0);
    check("rst_grp",   int'(grp_cnt), 0);
    rst_n = 1'b1;
    tick();
    check("rst_ready", int'(in_ready), 1);

    // Full triple, early last, last from S2
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].din, vecs[i].vld, vecs[i].lst, vecs[i].ordy);
      tick();
      check($sformatf("v%0d_ready", i), int'(in_ready), int'(vecs[i].e_rdy));
      check($sformatf("v%0d_valid", i), int'(out_valid), int'(vecs[i].e_ov));
      check($sformatf("v%0d_grp", i),   int'(grp_cnt), int'(vecs[i].e_grp));
      if (vecs[i].e_ov) begin
        check($sformatf("v%0d_a", i),    int'(a), int'(vecs[i].e_a));
        check($sformatf("v%0d_b", i),    int'(b), int'(vecs[i].e_b));
        check($sformatf("v%0d_c", i),    int'(c), int'(vecs[i].e_c));
        check($sformatf("v%0d_cnt", i),  int'(out_cnt), int'(vecs[i].e_cnt));
        check($sformatf("v%0d_last", i), int'(out_last), int'(vecs[i].e_last));
      end
    end

    // Backpressure: hold {1,2,3}, park {4,5,6}, refuse 7 while parked
    drive(4'd1, 1, 0, 0); tick();
    drive(4'd2, 1, 0, 0); tick();
    drive(4'd3, 1, 0, 0); tick();
    check_triple("bp_first", 1, 2, 3, 3, 0);
    drive(4'd4, 1, 0, 0); tick();
    drive(4'd5, 1, 0, 0); tick();
    drive(4'd6, 1, 0, 0); tick();
    check("bp_pend_ready", int'(in_ready), 0);
    check_triple("bp_hold", 1, 2, 3, 3, 0);
    drive(4'd7, 1, 0, 0); tick();
    check("bp_pend_ready2", int'(in_ready), 0);
    check_triple("bp_hold2", 1, 2, 3, 3, 0);
    drive(4'd7, 1, 0, 1); tick();
    check_triple("bp_swap", 4, 5, 6, 3, 0);
    check("bp_swap_ready", int'(in_ready), 1);
    check("bp_swap_grp",   int'(grp_cnt), 5);
    drive(4'd7, 1, 0, 0); tick();
    drive(4'd8, 1, 1, 0); tick();
    check("bp_pend2_ready", int'(in_ready), 0);
    check_triple("bp_hold3", 4, 5, 6, 3, 0);
    drive(4'd0, 0, 0, 1); tick();
    check_triple("bp_seven", 7, 8, 0, 2, 1);
    check("bp_grp6", int'(grp_cnt), 6);
    drive(4'd0, 0, 0, 1); tick();
    check("bp_drain_valid", int'(out_valid), 0);
    check("bp_drain_grp",   int'(grp_cnt), 7);

    // Reset while holding 8,9 in the collector
    drive(4'd8, 1, 0, 1); tick();
    drive(4'd9, 1, 0, 1); tick();
    rst_n = 1'b0;
    drive(4'd0, 0, 0, 1); tick();
    check("mr_valid", int'(out_valid), 0);
    check("mr_abc",   int'({a, b, c}), 0);
    check("mr_cnt",   int'(out_cnt), 0);
    check("mr_grp",   int'(grp_cnt), 0);
    rst_n = 1'b1;
    tick();
    check("mr_ready", int'(in_ready), 1);
    drive(4'd1, 1, 0, 1); tick();
    drive(4'd1, 1, 0, 1); tick();
    drive(4'd1, 1, 0, 1); tick();
    check_triple("mr_new", 1, 1, 1, 3, 0);

    // Streaming from a clean reset, then run grp_cnt through its wrap
    rst_n = 1'b0;
    drive(4'd0, 0, 0, 1); tick();
    rst_n = 1'b1;
    stall_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      drive(4'(i), 1, 0, 1);
      #1;
      if (!in_ready) stall_seen = 1'b1;
      tick();
      if (i % 3 == 2) check_triple($sformatf("st%0d", i / 3), (i - 2) % 16, (i - 1) % 16, i % 16, 3, 0);
    end
    drive(4'd0, 0, 0, 1); tick();
    check("st_no_stall", int'(stall_seen), 0);
    check("st_grp10",    int'(grp_cnt), 10);

    for (int i = 0; i < 245 * 3; i++) begin
      drive(4'(i), 1, 0, 1);
      tick();
    end
    drive(4'd0, 0, 0, 1); tick();
    check("wr_grp255", int'(grp_cnt), 255);
    for (int i = 0; i < 3; i++) begin
      drive(4'(i + 1), 1, 0, 1);
      tick();
    end
    check_triple("wr_last", 1, 2, 3, 3, 0);
    drive(4'd0, 0, 0, 1); tick();
    check("wr_grp0",  int'(grp_cnt), 0);
    check("wr_valid", int'(out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
